// File: rtl/spi_master_arbiter_pkg.sv
// Shared types and constants for the SPI master arbiter.
// Latency: none (types, constants and a width helper only).
// Backpressure: not applicable.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2,
    GAP   = 2'd3
  } arb_state_e;

  localparam int STATE_W            = 2;
  localparam int DEF_GAP_CYCLES     = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Index width for n requesters; a 2-way arbiter still needs one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_master_arbiter_if.sv
// Bundle of requester, shared-master and slave-pin signals around the arbiter.
// Latency: none (wiring only).
// Backpressure: req is a level held by the requester; grant/done close the loop.
interface spi_master_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] error;
  logic [N_REQ-1:0] slave_cs;
  logic [N_REQ-1:0] slave_miso;
  logic             busy;
  logic             drv_start;
  logic             drv_cs;
  logic             drv_miso;
  logic             drv_abort;

  // Arbiter view.
  modport master (
    input  req, drv_cs, slave_miso,
    output grant, done, error, slave_cs, busy, drv_start, drv_miso, drv_abort
  );

  // Environment view: requesters, shared SPI master and slave pins.
  modport slave (
    output req, drv_cs, slave_miso,
    input  grant, done, error, slave_cs, busy, drv_start, drv_miso, drv_abort
  );
endinterface

// File: rtl/spi_master_arbiter_rr_pick.sv
// Round-robin selector: first set request bit at or above ptr_i, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; output only reflects the current req_i.
module rr_pick
  import spi_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o
);

  logic found;
  int   j;

  // Scan pointer, pointer+1, ... with wrap; first hit wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    j        = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found       = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI master among N_REQ requesters: round-robin grant, one transaction per grant.
// Latency: grant 1 cycle after req; done/error registered, 1 cycle after the closing cs edge.
// Backpressure: req is held off until IDLE; optional SPI_ARB_TIMEOUT_EN aborts a stuck XFER.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  spi_master_arbiter_if.master bus
);

  localparam int IW = idx_w(N_REQ);
  localparam int GW = $clog2(GAP_CYCLES + 2);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             seen_low_q, seen_low_d;

  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    ptr_next;
  logic             xfer_done;
  logic             tmo_hit;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx)
  );

  // A transfer ends on cs returning high after it has been seen low.
  assign xfer_done = seen_low_q & bus.drv_cs;
  assign ptr_next  = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + IW'(1);

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]    tmo_q;
  logic             abort_q;
  logic [N_REQ-1:0] err_q;

  assign tmo_hit = (state_q == XFER) && !xfer_done && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Timeout counter runs only in XFER; abort/error pulse for one cycle on expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q   <= '0;
      abort_q <= 1'b0;
      err_q   <= '0;
    end else begin
      tmo_q   <= (state_q == XFER) ? tmo_q + TW'(1) : '0;
      abort_q <= tmo_hit;
      err_q   <= tmo_hit ? grant_q : '0;
    end
  end

  assign bus.drv_abort = abort_q;
  assign bus.error     = err_q;
`else
  assign tmo_hit       = 1'b0;
  assign bus.drv_abort = 1'b0;
  assign bus.error     = '0;
`endif

  // State and grant registers; reset drops grant so cs releases immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
      gap_q      <= '0;
      seen_low_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      gidx_q     <= gidx_d;
      ptr_q      <= ptr_d;
      gap_q      <= gap_d;
      seen_low_q <= seen_low_d;
    end
  end

  // Next-state: IDLE picks, START pulses the master, XFER waits for cs, GAP idles.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    gap_d      = gap_q;
    seen_low_d = seen_low_q;
    done_d     = '0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_d = pick_oh;
          gidx_d  = pick_idx;
          state_d = START;
        end
      end
      START: begin
        seen_low_d = 1'b0;
        state_d    = XFER;
      end
      XFER: begin
        if (!bus.drv_cs) seen_low_d = 1'b1;
        if (xfer_done || tmo_hit) begin
          if (xfer_done) done_d = grant_q;
          grant_d = '0;
          ptr_d   = ptr_next;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
        else                              gap_d   = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.drv_start = (state_q == START);
  assign bus.slave_cs  = ~grant_q | {N_REQ{bus.drv_cs}};
  assign bus.drv_miso  = (|grant_q) ? bus.slave_miso[gidx_q] : 1'b0;

endmodule
